// File: rtl/mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding, the
// captured request record and the address range helper.
package mem_responder_pkg;

    // Width of the requester's word address bus.
    localparam int unsigned REQ_ADDR_W = 16;

    // Natural data word width of the pipeline.
    localparam int unsigned UWORD_W = 16;

    // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    typedef logic [UWORD_W-1:0] uword_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mresp_state_t;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        uword_t                wdata;
    } memreq_t;

    // True when any address bit above the implemented array depth is set.
    function automatic logic addr_out_of_range(
        input logic [REQ_ADDR_W-1:0] addr,
        input int unsigned           aw
    );
        logic [REQ_ADDR_W-1:0] upper;
        upper = addr >> aw;
        return (upper != {REQ_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word array behind the responder: asynchronously cleared, written on the
// rising edge when enabled and not halted, read combinationally.
module mem_resp_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt_sys,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next array contents: one word replaced on an enabled, unhalted write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && !halt_sys) begin
            mem_d[addr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Array storage with asynchronous clear of every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read port sharing the registered request address.
    always_comb begin
        rdata = mem_q[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the data-memory request interface: accepts one request
// per handshake, waits a fixed latency, then presents a one-cycle response.
// halt_sys freezes the whole block, including a pending response.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt_sys,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic                  resp_write,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    // Counter value loaded on accept; WAIT leaves when it reaches one.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 32'd1);

    mresp_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    memreq_t            req_q, req_d;

    logic               ready_s;
    logic               accept_s;
    logic               in_resp_s;
    logic               err_s;
    logic               wr_en_s;
    logic [DATA_W-1:0]  rd_data_s;

    // Handshake and response-phase decode from the registered state.
    always_comb begin
        ready_s   = (state_q == IDLE) && !halt_sys && rst;
        accept_s  = req_valid && ready_s;
        in_resp_s = (state_q == RESP);
        err_s     = addr_out_of_range(req_q.addr, ADDR_W);
        wr_en_s   = in_resp_s && req_q.write && !err_s;
    end

    // Next-state, latency counter and request capture; halt holds everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        if (halt_sys) begin
            state_d = state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        req_d.write = req_write;
                        req_d.addr  = req_addr;
                        req_d.wdata = uword_t'(req_wdata);
                        cnt_d       = LAT_LOAD;
                        state_d     = (LATENCY == 32'd1) ? RESP : WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    // A zero count here is unreachable; leave rather than wrap.
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
                RESP: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM, counter and captured request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '{write: 1'b0, addr: 16'h0000, wdata: 16'h0000};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    mem_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst),
        .halt_sys (halt_sys),
        .wr_en    (wr_en_s),
        .addr     (req_q.addr[ADDR_W-1:0]),
        .wdata    (DATA_W'(req_q.wdata)),
        .rdata    (rd_data_s)
    );

    // Interface outputs; response fields are zero outside the RESP state.
    always_comb begin
        req_ready  = ready_s;
        busy       = (state_q != IDLE);
        resp_valid = in_resp_s && !halt_sys;
        resp_write = in_resp_s && req_q.write;
        resp_err   = in_resp_s && err_s;
        if (in_resp_s && !req_q.write && !err_s) begin
            resp_rdata = rd_data_s;
        end else begin
            resp_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target (responder) end of the data-memory request interface driven by the pipeline memory stage.
- Accepts one load/store request per valid/ready handshake and models a fixed access latency.
- Commits stores to an internal word array and returns load data, or an error flag, as a one-cycle response pulse.
- Honours halt_sys by freezing in place.

Parameters:
- ADDR_W, 8, word-address bits implemented (array depth 2**ADDR_W)
- DATA_W, 16, data word width (matches types_pkg::uword)
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- halt_sys  in  1  global halt; freezes FSM, counter and array
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  16  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response pulse
- resp_write  out  1  echo of the accepted req_write
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  address out of range (req_addr[15:ADDR_W] != 0)
- busy  out  1  request in flight (state != IDLE)

Behaviour:
- Reset (rst low, async):
  - state = IDLE, counter = 0, all captured request fields = 0.
  - Every array word = 0.
  - req_ready = 0 while rst is low; resp_valid = 0, resp_write = 0, resp_rdata = 0, resp_err = 0, busy = 0.
- req_ready = (state == IDLE) && !halt_sys && rst. Combinational.
- Accept happens on a cycle with req_valid && req_ready. On that edge:
  - Capture write, addr, wdata.
  - Load counter = LATENCY-1.
  - If LATENCY == 1, go to RESP; otherwise go to WAIT.
- WAIT: decrement counter each unhalted cycle. When counter == 1, go to RESP on that edge.
- Response timing: a request accepted in cycle k gives resp_valid = 1 in cycle k+LATENCY, for exactly one cycle. The FSM returns to IDLE in cycle k+LATENCY+1.
- RESP, in-range store:
  - Array write at the closing edge of the RESP cycle.
  - resp_rdata = 0, resp_err = 0, resp_write = 1.
- RESP, in-range load: resp_rdata = array[addr[ADDR_W-1:0]], combinational read, registered address.
- RESP, out-of-range address: resp_err = 1, resp_rdata = 0, no array write.
- Response outputs are 0 in every state other than RESP.
- Throughput: at most one request per LATENCY+1 cycles. req_ready is 0 in WAIT and RESP. No pipelining and no request queue.
- Read-after-write: a load accepted after a store response observes the stored value.
- halt_sys = 1:
  - No state, counter or array change.
  - req_ready = 0 and resp_valid forced to 0.
  - If halted in RESP, the response is re-presented in the first unhalted cycle.
- Reset during WAIT or RESP aborts the request. No write occurs and no response is issued.
- req_valid while req_ready = 0 is ignored. The requester must hold the request until accepted.
- FSM states: IDLE, WAIT, RESP. Any illegal encoding recovers to IDLE.

Decomposition:
- types_pkg gains:
  - mresp_state_t, enum IDLE/WAIT/RESP.
  - memreq_t, struct {write, addr, wdata}.
- Top module contains the handshake, FSM, latency counter and range check.
- One sub-module, mem_resp_array:
  - 2**ADDR_W x DATA_W.
  - Async-clear on rst, sync write gated by !halt_sys, async read.

Test Plan:
- Reset then idle: rst low for 3 cycles, then release -> req_ready 0 during reset, 1 in the first cycle after release; all response outputs 0; busy 0.
- Store then load, LATENCY=2: store addr 0x0010, data 0xBEEF, accepted in cycle 5 -> resp_valid, resp_write=1 in cycle 7. Then load 0x0010 accepted in cycle 8 -> resp_valid in cycle 10 with resp_rdata 0xBEEF, resp_err 0.
- Back-to-back: req_valid held high with 4 loads -> accepts exactly every 3 cycles; req_ready low in WAIT and RESP; 4 responses delivered in order.
- Out of range: load and store to 0x0100 (ADDR_W=8) -> resp_err 1, resp_rdata 0; a later load of 0x0000 still returns 0.
- Halt: halt_sys asserted in the RESP cycle for 4 cycles -> resp_valid 0 during halt, asserted once on the first unhalted cycle; the write commits once.
- Async reset mid-WAIT: rst pulsed low between clock edges during a store to 0x0020 -> outputs clear immediately, no response, a later load of 0x0020 returns 0. Repeat with LATENCY=1 to check the direct IDLE->RESP path.
